// File: rtl/mem_sum_ctrl_if.sv
// Bus between the sum controller, its requester and the 1024x16 data memory.
// The slave modport is the controller side; master is the requester/memory side.
interface mem_sum_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_adr;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] dst_adr;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
    logic              memwen;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] sum;
    logic              ovf;

    modport slave (
        input  start, base_adr, count, dst_adr, rdata,
        output adr, wdata, memwen, busy, done, sum, ovf
    );

    modport master (
        output start, base_adr, count, dst_adr, rdata,
        input  adr, wdata, memwen, busy, done, sum, ovf
    );
endinterface

// File: rtl/mem_sum_ctrl.sv
// Walks a run of consecutive memory words, sums them modulo 2^DATA_W and
// writes the sum back to a destination word. All outputs are registered.
module mem_sum_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    mem_sum_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] adr_q;
    logic [ADDR_W-1:0] rem_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] sum_q;
    logic              ovf_q;
    logic              memwen_q;
    logic              done_q;
    logic [DATA_W:0]   acc_d;

    // Extra top bit carries the unsigned overflow of each partial add.
    assign acc_d = {1'b0, acc_q} + {1'b0, bus.rdata};

    // adr_q doubles as the read pointer while in READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            rem_q    <= '0;
            dst_q    <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
            ovf_q    <= 1'b0;
            memwen_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                        rem_q <= bus.count;
                        dst_q <= bus.dst_adr;
                        if (bus.count != '0) begin
                            state_q <= READ;
                            adr_q   <= bus.base_adr;
                        end else begin
                            state_q  <= WRITE;
                            adr_q    <= bus.dst_adr;
                            memwen_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    acc_q <= acc_d[DATA_W-1:0];
                    ovf_q <= ovf_q | acc_d[DATA_W];
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == ADDR_W'(1)) begin
                        state_q  <= WRITE;
                        adr_q    <= dst_q;
                        memwen_q <= 1'b1;
                    end else begin
                        adr_q <= adr_q + 1'b1;
                    end
                end
                WRITE: begin
                    state_q  <= DONE;
                    adr_q    <= '0;
                    memwen_q <= 1'b0;
                    done_q   <= 1'b1;
                    sum_q    <= acc_q;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.adr    = adr_q;
    assign bus.wdata  = acc_q;
    assign bus.memwen = memwen_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.sum    = sum_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_mem_sum_ctrl.sv
// Bench for mem_sum_ctrl: behavioural memory plus a plain-arithmetic model of
// the expected sum, carry flag, address walk and handshake timing.
module tb_mem_sum_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_sum_ctrl_if ifc ();
    mem_sum_ctrl dut (.clk(clk), .rst(rst), .bus(ifc));

    logic [15:0] mem [0:1023];
    logic        tb_we;
    logic [9:0]  tb_wa;
    logic [15:0] tb_wd;

    assign ifc.rdata = mem[ifc.adr];
    always @(posedge clk) begin
        if (ifc.memwen) mem[ifc.adr] <= ifc.wdata;
        else if (tb_we) mem[tb_wa] <= tb_wd;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input int d);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = 10'(a); tb_wd = 16'(d);
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // rst_at < 0: run to completion; else assert rst during READ cycle rst_at.
    task automatic run_op(input int base, input int cnt, input int dst,
                          input bit mid_start, input int rst_at);
        int          s;
        bit          o;
        logic [15:0] old_dst;
        s = 0; o = 0;
        for (int i = 0; i < cnt; i++) begin
            s = s + int'(mem[(base + i) % 1024]);
            if (s > 65535) begin o = 1; s = s - 65536; end
        end
        old_dst = mem[dst];
        @(negedge clk);
        ifc.start = 1'b1; ifc.base_adr = 10'(base); ifc.count = 10'(cnt); ifc.dst_adr = 10'(dst);
        @(posedge clk); #1;
        ifc.start = 1'b0;
        for (int c = 0; c <= cnt + 2; c++) begin
            if (c < cnt) begin
                check("read_adr", 32'(ifc.adr), 32'((base + c) % 1024));
                check("read_wen", 32'(ifc.memwen), 0);
                check("read_busy", 32'(ifc.busy), 1);
            end else if (c == cnt) begin
                check("wr_wen", 32'(ifc.memwen), 1);
                check("wr_adr", 32'(ifc.adr), 32'(dst));
                check("wr_data", 32'(ifc.wdata), 32'(s));
                check("wr_done", 32'(ifc.done), 0);
            end else if (c == cnt + 1) begin
                check("done", 32'(ifc.done), 1);
                check("done_busy", 32'(ifc.busy), 1);
                check("done_wen", 32'(ifc.memwen), 0);
                check("done_adr", 32'(ifc.adr), 0);
                check("sum", 32'(ifc.sum), 32'(s));
                check("ovf", 32'(ifc.ovf), 32'(o));
                check("mem_dst", 32'(mem[dst]), 32'(s));
            end else begin
                check("idle_done", 32'(ifc.done), 0);
                check("idle_busy", 32'(ifc.busy), 0);
            end
            if (mid_start && c == 2 && cnt > 4) begin
                ifc.start = 1'b1; ifc.base_adr = 10'($urandom); ifc.count = 10'd1;
                ifc.dst_adr = 10'($urandom);
            end
            if (c == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_adr", 32'(ifc.adr), 0);
                check("rst_wdata", 32'(ifc.wdata), 0);
                check("rst_wen", 32'(ifc.memwen), 0);
                check("rst_busy", 32'(ifc.busy), 0);
                check("rst_done", 32'(ifc.done), 0);
                check("rst_sum", 32'(ifc.sum), 0);
                check("rst_ovf", 32'(ifc.ovf), 0);
                for (int k = 0; k < cnt + 3; k++) begin
                    @(posedge clk); #1;
                    check("rst_no_done", 32'(ifc.done), 0);
                    check("rst_no_wen", 32'(ifc.memwen), 0);
                end
                check("rst_mem_dst", 32'(mem[dst]), 32'(old_dst));
                return;
            end
            @(posedge clk); #1;
            ifc.start = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        ifc.start = 1'b0; ifc.base_adr = '0; ifc.count = '0; ifc.dst_adr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7);
        repeat (2) @(posedge clk);
        #1;
        check("reset_adr", 32'(ifc.adr), 0);
        check("reset_wdata", 32'(ifc.wdata), 0);
        check("reset_wen", 32'(ifc.memwen), 0);
        check("reset_busy", 32'(ifc.busy), 0);
        check("reset_done", 32'(ifc.done), 0);
        check("reset_sum", 32'(ifc.sum), 0);
        check("reset_ovf", 32'(ifc.ovf), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) poke(10 + i, i + 1);
        run_op(10, 10, 20, 1'b0, -1);
        check("plan_sum55", 32'(ifc.sum), 55);

        run_op(100, 0, 30, 1'b0, -1);
        check("plan_cnt0_mem", 32'(mem[30]), 0);

        poke(1022, 1); poke(1023, 2); poke(0, 3); poke(1, 4);
        run_op(1022, 4, 500, 1'b0, -1);
        check("plan_wrap", 32'(ifc.sum), 10);

        poke(40, 16'hFFFF); poke(41, 16'h0002);
        run_op(40, 2, 50, 1'b0, -1);
        check("plan_ovf_sum", 32'(ifc.sum), 1);
        check("plan_ovf_flag", 32'(ifc.ovf), 1);
        run_op(10, 2, 51, 1'b0, -1);
        check("plan_ovf_clr_sum", 32'(ifc.sum), 3);
        check("plan_ovf_clr", 32'(ifc.ovf), 0);

        run_op(10, 10, 20, 1'b1, -1);
        check("plan_mid_start", 32'(ifc.sum), 55);

        poke(20, 16'hBEEF);
        run_op(10, 10, 20, 1'b0, 4);

        // dst inside the read range must see pre-operation data
        run_op(12, 5, 14, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            int b;
            int n;
            b = int'($urandom_range(0, 1023));
            n = int'($urandom_range(0, 24));
            for (int i = 0; i < n; i++) poke((b + i) % 1024, int'($urandom_range(0, 65535)));
            run_op(b, n, int'($urandom_range(0, 1023)), r[0], -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
